arb_req_buffer: RTL and testbench
=================================

// Module: arb_req_buffer
// PURPOSE
//  Per-requester ingress buffer placed directly upstream of round_robinArb.
//  Queues N independent valid/ready request streams, drives the arbiter req vector
//  (bit i = channel i non-empty), pops the channel the arbiter grants and presents
//  the winning beat with its source ID on a single valid/ready output port.
// PARAMETERS
//  N      4  number of requester channels; must equal the arbiter's N, >=2
//  DW     8  payload width per beat
//  DEPTH  4  entries per channel FIFO; power of 2, >=2
// PORTS
//  clk        in   1            clock; all logic on posedge
//  rst        in   1            synchronous, active-high reset
//  in_valid   in   N            per-channel beat valid
//  in_data    in   N*DW         channel i payload at [i*DW +: DW]
//  in_ready   out  N            per-channel accept (= channel not full)
//  req        out  N            to arbiter req; bit i = channel i FIFO non-empty
//  arb_en     out  1            to arbiter en; = |req & (~out_valid | out_ready)
//  grant      in   N            from arbiter; one-hot or zero
//  grant_ID   in   $clog2(N)    from arbiter; index of the set grant bit
//  out_valid  out  1            output beat valid (registered)
//  out_data   out  DW           output payload (registered)
//  out_id     out  $clog2(N)    source channel of out_data (registered)
//  out_ready  in   1            downstream accept
//  err        out  1            sticky protocol-error flag
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all FIFOs emptied, counts/pointers 0; req=0,
//    in_ready=all 1s, arb_en=0, out_valid=0, out_data=0, out_id=0, err=0.
//    Reset mid-operation discards all queued and output beats; no partial state kept.
//  - Per channel: rd/wr ptr $clog2(DEPTH) bits, wrap modulo DEPTH; count
//    $clog2(DEPTH+1) bits, 0..DEPTH. full = (count==DEPTH), empty = (count==0).
//  - Push: in_valid[i] & in_ready[i] at posedge writes in_data slice, count+1.
//    in_ready[i] = ~full[i] only (no same-cycle pass-through when full).
//  - req/in_ready are combinational from registered counts: beat pushed at edge t
//    raises req[i] in the cycle following t.
//  - Output slot free = ~out_valid | out_ready.
//  - Pop: at posedge with slot free, grant one-hot, grant[k] & req[k], and
//    grant_ID==k: pop channel k head; out_data<=head, out_id<=k, out_valid<=1.
//  - out_valid & out_ready with no pop that edge -> out_valid<=0 (data held).
//  - Back-to-back: slot free with out_ready=1 sustains 1 beat/cycle.
//  - Simultaneous push and pop on same channel: count unchanged, FIFO order kept.
//  - grant ignored (no pop) when: slot not free; grant==0; grant not one-hot;
//    grant[k] on empty channel; grant_ID != k. All but slot-not-free and
//    grant==0 set err=1, cleared only by rst.
//  - Latency: push at edge t -> req at t+1 -> earliest out_valid one cycle after
//    the arbiter's grant is sampled.
//  - No arbitration here; fairness is the arbiter's. Per-channel order strictly FIFO.
// TESTING (bench models arbiter with a round-robin reference)
//  1 Reset: rst=1 2 cycles -> req=0000, in_ready=1111, out_valid=0, err=0.
//  2 Push 0xA1,0xA2 on ch1 and 0xB1 on ch3, out_ready=1 -> outputs in arbiter
//    order, each with correct out_id (1 or 3), ch1 data in order A1 then A2.
//  3 Fill ch0 with 4 beats, out_ready=0 -> in_ready[0]=0 after 4th; 5th held
//    off; out_valid/out_data stable until out_ready=1; then drain 4 in order.
//  4 Full ch2 with simultaneous push 0x55 and grant to ch2 -> in_ready[2]=0,
//    no push that edge; pop succeeds; count DEPTH-1; 0x55 accepted next cycle.
//  5 Drive grant=0101, then grant=0100 with grant_ID=1, then grant to an empty
//    channel -> no pops, FIFO contents unchanged, err=1 and stays 1.
//  6 Queue 3 beats across channels, assert rst mid-stream -> next cycle req=0,
//    out_valid=0, err=0; later pushes emerge with no stale data.

Source files
------------

// File: rtl/arb_req_buffer.sv
// Purpose: per-requester FIFO bank ahead of a round-robin arbiter; pops the granted channel onto one output port.
// Latency: push at edge t raises req at t+1; the beat appears on out_* one cycle after its grant is sampled.
// Backpressure: in_ready[i] drops when channel i is full; grants are ignored while the output slot is occupied and not accepted.
module arb_req_buffer #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    input  logic [N*DW-1:0]      in_data,
    output logic [N-1:0]         in_ready,
    output logic [N-1:0]         req,
    output logic                 arb_en,
    input  logic [N-1:0]         grant,
    input  logic [$clog2(N)-1:0] grant_ID,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_id,
    input  logic                 out_ready,
    output logic                 err
);

    localparam int IW = $clog2(N);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q    [N][DEPTH];
    logic [DW-1:0] mem_d    [N][DEPTH];
    logic [PW-1:0] wr_ptr_q [N];
    logic [PW-1:0] wr_ptr_d [N];
    logic [PW-1:0] rd_ptr_q [N];
    logic [PW-1:0] rd_ptr_d [N];
    logic [CW-1:0] cnt_q    [N];
    logic [CW-1:0] cnt_d    [N];

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q,  out_data_d;
    logic [IW-1:0] out_id_q,    out_id_d;
    logic          err_q,       err_d;

    logic [N-1:0]  push;
    logic [N-1:0]  pop_sel;
    logic          slot_free;
    logic          grant_onehot;
    logic          grant_id_ok;
    logic          pop_ok;
    logic          err_set;
    logic [DW-1:0] head_dat;

    // Channel status straight from the registered counts; no pass-through when full.
    always_comb begin
        req      = '0;
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            req[i]      = (cnt_q[i] != '0);
            in_ready[i] = (cnt_q[i] != CW'(DEPTH));
        end
        push      = in_valid & in_ready;
        slot_free = ~out_valid_q | out_ready;
        arb_en    = (|req) & slot_free;
    end

    // Grant qualification: pop only on a clean one-hot grant that agrees with
    // grant_ID and targets a non-empty channel; anything else malformed is flagged.
    always_comb begin
        grant_onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);
        grant_id_ok  = (32'(grant_ID) < N);
        pop_ok       = 1'b0;
        if (slot_free && grant_onehot && grant_id_ok) begin
            pop_ok = grant[grant_ID] & req[grant_ID];
        end
        pop_sel  = pop_ok ? (N'(1) << grant_ID) : '0;
        err_set  = slot_free && (grant != '0) && !pop_ok;
        head_dat = grant_id_ok ? mem_q[grant_ID][rd_ptr_q[grant_ID]] : '0;
    end

    // Per-channel FIFO next state: write at wr_ptr, advance rd_ptr on pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = in_data[i*DW +: DW];
                wr_ptr_d[i]           = wr_ptr_q[i] + PW'(1);
            end
            if (pop_sel[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            end
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop_sel[i]);
        end
    end

    // Output slot: load on pop, clear valid when accepted without a refill; data held.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (pop_ok) begin
            out_valid_d = 1'b1;
            out_data_d  = head_dat;
            out_id_d    = grant_ID;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        err_d = err_q | err_set;
    end

    // Control state; reset empties every channel and the output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            err_q       <= err_d;
        end
    end

    // Payload storage needs no reset: entries are only read below the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign err       = err_q;

endmodule

// File: tb/tb_arb_req_buffer.sv
// Bench for arb_req_buffer: vector table for reset/basic flow/bad grants,
// hand sequences for full-channel, output stall and mid-stream reset.
module tb_arb_req_buffer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  req;
    logic        arb_en;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;
    logic        err;

    always #5 clk = ~clk;

    arb_req_buffer #(.N(4), .DW(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .arb_en    (arb_en),
        .grant     (grant),
        .grant_ID  (grant_id),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .err       (err)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic [3:0]  gnt;
        logic [1:0]  gid;
        logic        ordy;
        logic [3:0]  e_req;
        logic [3:0]  e_rdy;
        logic        e_en;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_oid;
        logic        e_err;
    } vec_t;

    vec_t        vecs[13];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rr_last = N - 1;
    logic [7:0]  exp_dat[$];
    logic [1:0]  exp_id[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Round-robin arbiter stand-in; drains until the expected queue is empty.
    task automatic drain(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (exp_dat.size() == 0) break;
            out_ready = 1'b1;
            grant     = '0;
            grant_id  = '0;
            #1;
            if (arb_en) begin
                for (int off = 1; off <= N; off++) begin
                    int idx;
                    idx = (rr_last + off) % N;
                    if (req[idx]) begin
                        grant    = 4'(1 << idx);
                        grant_id = 2'(idx);
                        rr_last  = idx;
                        break;
                    end
                end
            end
            tick();
            if (out_valid) begin
                chk("drain_dat", 32'(out_data), 32'(exp_dat.pop_front()));
                chk("drain_id", 32'(out_id), 32'(exp_id.pop_front()));
            end
        end
        grant    = '0;
        grant_id = '0;
        chk("drain_left", 32'(exp_dat.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rst  vld   dat            gnt   gid  ordy | req   rdy   en   ov   od     oid  err
        vecs[0]  = '{1'b1, 4'h0, 32'h0,         4'h0, 2'd0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 4'h0, 32'h0,         4'h0, 2'd0, 1'b0, 4'h0, 4'hF, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'hA, 32'hB100A100,  4'h0, 2'd0, 1'b1, 4'hA, 4'hF, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 4'h2, 32'h0000A200,  4'h2, 2'd1, 1'b1, 4'hA, 4'hF, 1'b1, 1'b1, 8'hA1, 2'd1, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,         4'h8, 2'd3, 1'b1, 4'h2, 4'hF, 1'b1, 1'b1, 8'hB1, 2'd3, 1'b0};
        vecs[5]  = '{1'b0, 4'h0, 32'h0,         4'h2, 2'd1, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 8'hA2, 2'd1, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 32'h0,         4'h0, 2'd0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 8'hA2, 2'd1, 1'b0};
        vecs[7]  = '{1'b0, 4'h1, 32'h00000077,  4'h0, 2'd0, 1'b1, 4'h1, 4'hF, 1'b1, 1'b0, 8'hA2, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 32'h0,         4'h5, 2'd0, 1'b1, 4'h1, 4'hF, 1'b1, 1'b0, 8'hA2, 2'd1, 1'b1};
        vecs[9]  = '{1'b0, 4'h0, 32'h0,         4'h4, 2'd1, 1'b1, 4'h1, 4'hF, 1'b1, 1'b0, 8'hA2, 2'd1, 1'b1};
        vecs[10] = '{1'b0, 4'h0, 32'h0,         4'h2, 2'd1, 1'b1, 4'h1, 4'hF, 1'b1, 1'b0, 8'hA2, 2'd1, 1'b1};
        vecs[11] = '{1'b0, 4'h0, 32'h0,         4'h1, 2'd0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1, 8'h77, 2'd0, 1'b1};
        vecs[12] = '{1'b0, 4'h0, 32'h0,         4'h0, 2'd0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 8'h77, 2'd0, 1'b1};

        rst = 1'b1; in_valid = '0; in_data = '0; grant = '0; grant_id = '0; out_ready = 1'b0;

        // Reset, basic two-channel flow, malformed grants
        for (int v = 0; v < 13; v++) begin
            rst       = vecs[v].rst;
            in_valid  = vecs[v].vld;
            in_data   = vecs[v].dat;
            grant     = vecs[v].gnt;
            grant_id  = vecs[v].gid;
            out_ready = vecs[v].ordy;
            tick();
            chk($sformatf("v%0d_req", v),       32'(req),       32'(vecs[v].e_req));
            chk($sformatf("v%0d_in_ready", v),  32'(in_ready),  32'(vecs[v].e_rdy));
            chk($sformatf("v%0d_arb_en", v),    32'(arb_en),    32'(vecs[v].e_en));
            chk($sformatf("v%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].e_ov));
            chk($sformatf("v%0d_out_data", v),  32'(out_data),  32'(vecs[v].e_od));
            chk($sformatf("v%0d_out_id", v),    32'(out_id),    32'(vecs[v].e_oid));
            chk($sformatf("v%0d_err", v),       32'(err),       32'(vecs[v].e_err));
        end

        // Mid-stream reset (err is still set from the bad grants above)
        in_valid = 4'b1011; in_data = 32'hE300E1E0; grant = '0; out_ready = 1'b0;
        tick();
        in_valid = '0; grant = 4'b0001; grant_id = 2'd0;
        tick();
        chk("rst6_pre_ov", 32'(out_valid), 32'd1);
        chk("rst6_pre_od", 32'(out_data), 32'hE0);
        grant = '0; in_valid = 4'b1011; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = '0;
        #1;
        chk("rst6_req", 32'(req), 32'h0);
        chk("rst6_ov", 32'(out_valid), 32'd0);
        chk("rst6_err", 32'(err), 32'd0);
        chk("rst6_od", 32'(out_data), 32'h0);
        chk("rst6_in_ready", 32'(in_ready), 32'hF);
        rr_last = N - 1;
        in_valid = 4'b0110; in_data = 32'h00F2F100;
        tick();
        in_valid = '0;
        exp_dat.push_back(8'hF1); exp_id.push_back(2'd1);
        exp_dat.push_back(8'hF2); exp_id.push_back(2'd2);
        drain(16);

        // Fill ch0, stall output, then drain in order
        rst = 1'b1; out_ready = 1'b0; grant = '0;
        tick();
        rst = 1'b0; rr_last = N - 1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b0001; in_data = 32'(8'hC0 + k);
            tick();
            chk($sformatf("fill0_in_ready_%0d", k), 32'(in_ready[0]), (k < 3) ? 32'd1 : 32'd0);
        end
        in_data = 32'h000000C4;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("fill0_held_off", 32'(in_ready[0]), 32'd0);
        end
        in_valid = '0; grant = 4'b0001; grant_id = 2'd0;
        tick();
        chk("stall_ov", 32'(out_valid), 32'd1);
        chk("stall_od", 32'(out_data), 32'hC0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold_ov", 32'(out_valid), 32'd1);
            chk("stall_hold_od", 32'(out_data), 32'hC0);
            chk("stall_err", 32'(err), 32'd0);
        end
        grant = '0;
        rr_last = N - 1;
        for (int k = 1; k < 4; k++) begin
            exp_dat.push_back(8'(8'hC0 + k)); exp_id.push_back(2'd0);
        end
        drain(16);
        out_ready = 1'b1;
        tick();
        chk("fill0_empty_req", 32'(req), 32'h0);

        // Full ch2: push and pop on the same edge
        rst = 1'b1;
        tick();
        rst = 1'b0; rr_last = N - 1; out_ready = 1'b1; grant = '0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b0100; in_data = {8'h00, 8'(8'hD0 + k), 16'h0000};
            tick();
        end
        in_data = 32'h00550000; grant = 4'b0100; grant_id = 2'd2;
        #1;
        chk("full2_in_ready", 32'(in_ready[2]), 32'd0);
        tick();
        chk("full2_pop_ov", 32'(out_valid), 32'd1);
        chk("full2_pop_od", 32'(out_data), 32'hD0);
        chk("full2_pop_oid", 32'(out_id), 32'd2);
        chk("full2_room", 32'(in_ready[2]), 32'd1);
        grant = '0;
        tick();
        chk("full2_refill", 32'(in_ready[2]), 32'd0);
        in_valid = '0;
        rr_last = N - 1;
        exp_dat.push_back(8'hD1); exp_id.push_back(2'd2);
        exp_dat.push_back(8'hD2); exp_id.push_back(2'd2);
        exp_dat.push_back(8'hD3); exp_id.push_back(2'd2);
        exp_dat.push_back(8'h55); exp_id.push_back(2'd2);
        drain(16);
        tick();
        chk("full2_empty_req", 32'(req), 32'h0);
        chk("full2_empty_ov", 32'(out_valid), 32'd0);
        chk("final_err", 32'(err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
